// File: rtl/stage_sequencer.sv
// stage_sequencer: one-hot FETCH/REGFETCH/EXECUTE/DATAMEM/WRITEBACK strobe controller with a timed memory handshake.
// Latency: 4 cycles per instruction, plus n DATAMEM cycles for executed loads/stores; back-to-back issue has no bubble.
// Backpressure: a low mem_ack holds DATAMEM for up to MEM_TIMEOUT cycles, then HALT; optional `SINGLE_STEP_EN adds step_req.
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             run,
    input  logic             is_mem,
    input  logic             is_branch,
    input  logic             cond_pass,
    input  logic             mem_ack,
`ifdef SINGLE_STEP_EN
    input  logic             step_req,
`endif
    output logic             fetch_go,
    output logic             regfetch_go,
    output logic             execute_go,
    output logic             datamem_go,
    output logic             writeback_go,
    output logic             mem_req,
    output logic             reg_write_en,
    output logic             pc_write_en,
    output logic             branch_take,
    output logic             mem_timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_REGFETCH  = 3'b001,
        S_EXECUTE   = 3'b010,
        S_DATAMEM   = 3'b011,
        S_WRITEBACK = 3'b100,
        S_HALT      = 3'b101,
        S_IDLE      = 3'b110
    } state_t;

    state_t     cur, nxt;
    logic       mem_l, br_l, pass_l;
    logic [7:0] wait_cnt;
    logic       stall_cyc, expire;
    logic       step_l;

    // wait_cnt holds the number of ack-low cycles already spent in this DATAMEM visit
    assign stall_cyc = (cur == S_DATAMEM) && !mem_ack;
    assign expire    = stall_cyc && (wait_cnt == 8'(MEM_TIMEOUT - 1));
    assign state     = cur;

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE: begin
                if (run) begin
                    nxt = S_FETCH;
                end
`ifdef SINGLE_STEP_EN
                else if (step_req) begin
                    nxt = S_FETCH;
                end
`endif
            end
            S_FETCH:    nxt = S_REGFETCH;
            S_REGFETCH: nxt = S_EXECUTE;
            S_EXECUTE:  nxt = (mem_l && cond_pass) ? S_DATAMEM : S_WRITEBACK;
            S_DATAMEM: begin
                if (mem_ack) begin
                    nxt = S_WRITEBACK;
                end else if (expire) begin
                    nxt = S_HALT;
                end
            end
            S_WRITEBACK: begin
                nxt = run ? S_FETCH : S_IDLE;
`ifdef SINGLE_STEP_EN
                if (step_l) begin
                    nxt = S_IDLE;
                end
`endif
            end
            S_HALT:  nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fetch_go     = 1'b0;
        regfetch_go  = 1'b0;
        execute_go   = 1'b0;
        datamem_go   = 1'b0;
        writeback_go = 1'b0;
        mem_req      = 1'b0;
        reg_write_en = 1'b0;
        pc_write_en  = 1'b0;
        branch_take  = 1'b0;
        case (cur)
            S_FETCH:    fetch_go    = 1'b1;
            S_REGFETCH: regfetch_go = 1'b1;
            S_EXECUTE:  execute_go  = 1'b1;
            S_DATAMEM: begin
                mem_req    = 1'b1;
                datamem_go = mem_ack;
            end
            S_WRITEBACK: begin
                writeback_go = 1'b1;
                pc_write_en  = 1'b1;
                reg_write_en = pass_l && !br_l;
                branch_take  = pass_l && br_l;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (nreset) begin
            cur         <= S_IDLE;
            mem_l       <= 1'b0;
            br_l        <= 1'b0;
            pass_l      <= 1'b0;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
            instr_count <= '0;
            stall_count <= '0;
            step_l      <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_REGFETCH) begin
                mem_l <= is_mem;
                br_l  <= is_branch;
            end
            if (cur == S_EXECUTE) begin
                pass_l <= cond_pass;
            end
            wait_cnt <= stall_cyc ? wait_cnt + 8'd1 : 8'd0;
            if (expire) begin
                mem_timeout <= 1'b1;
            end
            if (stall_cyc && (stall_count != '1)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if ((cur == S_WRITEBACK) && (instr_count != '1)) begin
                instr_count <= instr_count + CNT_W'(1);
            end
`ifdef SINGLE_STEP_EN
            // a stepped instruction remembers it must park in IDLE after WRITEBACK
            if (cur == S_IDLE) begin
                step_l <= !run && step_req;
            end
`else
            step_l <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed vector table, hand-written corner sequences, and a randomized cycle-level model run.
module tb_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset, run, is_mem, is_branch, cond_pass, mem_ack;
`ifdef SINGLE_STEP_EN
    logic step_req;
`endif
    logic fetch_go, regfetch_go, execute_go, datamem_go, writeback_go;
    logic mem_req, reg_write_en, pc_write_en, branch_take, mem_timeout;
    logic [2:0]  state;
    logic [15:0] instr_count, stall_count;

    logic s_f, s_r, s_e, s_d, s_w, s_mreq, s_rwe, s_pcwe, s_bt, s_to;
    logic [2:0] s_state;
    logic [1:0] s_ic, s_sc;

    stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
        .clk(clk), .nreset(nreset), .run(run), .is_mem(is_mem), .is_branch(is_branch),
        .cond_pass(cond_pass), .mem_ack(mem_ack),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .fetch_go(fetch_go), .regfetch_go(regfetch_go), .execute_go(execute_go),
        .datamem_go(datamem_go), .writeback_go(writeback_go), .mem_req(mem_req),
        .reg_write_en(reg_write_en), .pc_write_en(pc_write_en), .branch_take(branch_take),
        .mem_timeout(mem_timeout), .state(state), .instr_count(instr_count), .stall_count(stall_count)
    );

    // narrow-counter copy used to observe saturation
    stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(2)) dut_s (
        .clk(clk), .nreset(nreset), .run(run), .is_mem(is_mem), .is_branch(is_branch),
        .cond_pass(cond_pass), .mem_ack(mem_ack),
`ifdef SINGLE_STEP_EN
        .step_req(step_req),
`endif
        .fetch_go(s_f), .regfetch_go(s_r), .execute_go(s_e), .datamem_go(s_d), .writeback_go(s_w),
        .mem_req(s_mreq), .reg_write_en(s_rwe), .pc_write_en(s_pcwe), .branch_take(s_bt),
        .mem_timeout(s_to), .state(s_state), .instr_count(s_ic), .stall_count(s_sc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ovec();
        return {fetch_go, regfetch_go, execute_go, datamem_go, writeback_go,
                mem_req, reg_write_en, pc_write_en, branch_take, mem_timeout};
    endfunction

    localparam logic [9:0] V_F  = 10'b1000000000;
    localparam logic [9:0] V_R  = 10'b0100000000;
    localparam logic [9:0] V_E  = 10'b0010000000;
    localparam logic [9:0] V_DW = 10'b0000010000;
    localparam logic [9:0] V_DA = 10'b0001010000;
    localparam logic [9:0] V_HALT = 10'b0000000001;

    task automatic do_reset();
        nreset = 1'b1; run = 1'b0; mem_ack = 1'b0;
        repeat (2) cyc();
        nreset = 1'b0;
        #1;
    endtask

    // Issues one instruction from IDLE with run dropped once fetch_go is seen.
    task automatic do_instr(input logic m, input logic b, input logic c, input int acklow,
                            output int lat, output logic rwe, output logic bt, output logic pcwe,
                            output int mreq, output int dgo, output logic done);
        bit started = 0;
        lat = 0; mreq = 0; dgo = 0; rwe = 0; bt = 0; pcwe = 0; done = 0;
        is_mem = m; is_branch = b; cond_pass = c; run = 1'b1;
        for (int k = 0; k < 64; k++) begin
            cyc();
            mem_ack = mem_req && (mreq == acklow);
            #1;
            if (fetch_go) begin
                started = 1;
                run = 1'b0;
            end
            if (started) lat++;
            if (mem_req) mreq++;
            if (datamem_go) dgo++;
            if (writeback_go) begin
                rwe = reg_write_en; bt = branch_take; pcwe = pc_write_en; done = 1;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    typedef struct {
        logic m, b, c;
        int   acklow;
        int   lat;
        logic rwe, bt;
        int   mreq, dgo, stall;
    } vec_t;

    typedef struct {
        logic [2:0] st;
        logic       im, ib, cp, ack;
        logic [9:0] ev;
    } cyc_t;

    cyc_t q[$];

    task automatic push_cyc(input logic [2:0] st, input logic im, input logic ib,
                            input logic cp, input logic ack, input logic [9:0] ev);
        cyc_t e;
        e.st = st; e.im = im; e.ib = ib; e.cp = cp; e.ack = ack; e.ev = ev;
        q.push_back(e);
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    initial begin
        vec_t tbl[7];
        int lat, mreq, dgo, bad, ic0, sc0, found;
        logic rwe, bt, pcwe, done;
        int n_instr, stall_tot, lo;
        logic m, b, c;

        nreset = 1'b1; run = 1'b0; is_mem = 1'b0; is_branch = 1'b0; cond_pass = 1'b0; mem_ack = 1'b0;
`ifdef SINGLE_STEP_EN
        step_req = 1'b0;
`endif
        repeat (2) cyc();
        chk("reset_state", 32'(state), 32'd6);
        chk("reset_outputs", 32'(ovec()), 32'd0);
        chk("reset_instr_count", 32'(instr_count), 32'd0);
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        nreset = 1'b0;
        cyc(); #1;
        chk("idle_holds_without_run", 32'(state), 32'd6);

        //           m     b     c   acklow lat  rwe   bt  mreq dgo stall
        tbl[0] = '{1'b0, 1'b0, 1'b1,  0,   4, 1'b1, 1'b0,  0,  0,  0};
        tbl[1] = '{1'b1, 1'b0, 1'b1,  3,   8, 1'b1, 1'b0,  4,  1,  3};
        tbl[2] = '{1'b1, 1'b0, 1'b0,  0,   4, 1'b0, 1'b0,  0,  0,  0};
        tbl[3] = '{1'b0, 1'b1, 1'b1,  0,   4, 1'b0, 1'b1,  0,  0,  0};
        tbl[4] = '{1'b0, 1'b1, 1'b0,  0,   4, 1'b0, 1'b0,  0,  0,  0};
        tbl[5] = '{1'b1, 1'b1, 1'b1,  0,   5, 1'b0, 1'b1,  1,  1,  0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 14,  19, 1'b1, 1'b0, 15,  1, 14};
        for (int i = 0; i < 7; i++) begin
            ic0 = int'(instr_count); sc0 = int'(stall_count);
            do_instr(tbl[i].m, tbl[i].b, tbl[i].c, tbl[i].acklow, lat, rwe, bt, pcwe, mreq, dgo, done);
            chk($sformatf("vec%0d_completed", i), 32'(done), 32'd1);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_reg_write_en", i), 32'(rwe), 32'(tbl[i].rwe));
            chk($sformatf("vec%0d_branch_take", i), 32'(bt), 32'(tbl[i].bt));
            chk($sformatf("vec%0d_pc_write_en", i), 32'(pcwe), 32'd1);
            chk($sformatf("vec%0d_mem_req_cycles", i), 32'(mreq), 32'(tbl[i].mreq));
            chk($sformatf("vec%0d_datamem_go_cycles", i), 32'(dgo), 32'(tbl[i].dgo));
            cyc(); #1;
            chk($sformatf("vec%0d_instr_delta", i), 32'(int'(instr_count) - ic0), 32'd1);
            chk($sformatf("vec%0d_stall_delta", i), 32'(int'(stall_count) - sc0), 32'(tbl[i].stall));
            chk($sformatf("vec%0d_back_to_idle", i), 32'(state), 32'd6);
            chk($sformatf("vec%0d_no_timeout", i), 32'(mem_timeout), 32'd0);
        end

        // back-to-back: second fetch_go directly follows WRITEBACK
        ic0 = int'(instr_count);
        is_mem = 1'b0; is_branch = 1'b0; cond_pass = 1'b1; run = 1'b1;
        cyc(); #1; chk("b2b_c1", 32'(ovec()), 32'(V_F));
        cyc(); #1; chk("b2b_c2", 32'(ovec()), 32'(V_R));
        cyc(); #1; chk("b2b_c3", 32'(ovec()), 32'(V_E));
        cyc(); #1; chk("b2b_c4", 32'(ovec()), 32'(10'b0000101100));
        cyc(); #1; chk("b2b_c5", 32'(ovec()), 32'(V_F));
        chk("b2b_instr_count", 32'(int'(instr_count) - ic0), 32'd1);

        // run dropped during EXECUTE: instruction completes, then IDLE with no fetch
        found = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(); #1;
            if (execute_go) begin found = 1; break; end
        end
        chk("rundrop_reached_execute", 32'(found), 32'd1);
        run = 1'b0;
        cyc(); #1;
        chk("rundrop_writeback", 32'(writeback_go), 32'd1);
        bad = 0;
        repeat (5) begin
            cyc(); #1;
            if (fetch_go || state != 3'b110) bad++;
        end
        chk("rundrop_idle_no_fetch", 32'(bad), 32'd0);

        // timeout: mem_ack never arrives
        do_reset();
        run = 1'b1; is_mem = 1'b1; is_branch = 1'b0; cond_pass = 1'b1; mem_ack = 1'b0;
        mreq = 0; found = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(); #1;
            if (mem_req) mreq++;
            if (state == 3'b101) begin found = 1; break; end
        end
        chk("timeout_reached_halt", 32'(found), 32'd1);
        chk("timeout_datamem_cycles", 32'(mreq), 32'd15);
        chk("timeout_flag", 32'(mem_timeout), 32'd1);
        chk("timeout_stall_count", 32'(stall_count), 32'd15);
        chk("timeout_instr_count", 32'(instr_count), 32'd0);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            mem_ack = rb();
            #1;
            if (ovec() != V_HALT || state != 3'b101) bad++;
        end
        chk("halt_hold_20_cycles", 32'(bad), 32'd0);
        nreset = 1'b1; run = 1'b0; mem_ack = 1'b0;
        cyc(); #1;
        chk("halt_reset_state", 32'(state), 32'd6);
        chk("halt_reset_timeout", 32'(mem_timeout), 32'd0);
        chk("halt_reset_counts", 32'({instr_count, stall_count}), 32'd0);
        nreset = 1'b0;

`ifdef SINGLE_STEP_EN
        ic0 = int'(instr_count);
        is_mem = 1'b0; cond_pass = 1'b1; run = 1'b0;
        step_req = 1'b1;
        cyc();
        step_req = 1'b0;
        #1;
        found = fetch_go ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            cyc(); #1;
            if (fetch_go) found++;
        end
        chk("step_one_fetch", 32'(found), 32'd1);
        chk("step_instr_delta", 32'(int'(instr_count) - ic0), 32'd1);
        chk("step_back_to_idle", 32'(state), 32'd6);
`endif

        // randomized run under continuous run=1 against the cycle-level model
        do_reset();
        n_instr = 40; stall_tot = 0;
        for (int i = 0; i < n_instr; i++) begin
            m = rb(); b = rb(); c = rb();
            push_cyc(3'b000, rb(), rb(), rb(), rb(), V_F);
            push_cyc(3'b001, m, b, rb(), rb(), V_R);
            push_cyc(3'b010, rb(), rb(), c, rb(), V_E);
            if (m && c) begin
                lo = ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 5);
                for (int j = 0; j < lo; j++) push_cyc(3'b011, rb(), rb(), rb(), 1'b0, V_DW);
                push_cyc(3'b011, rb(), rb(), rb(), 1'b1, V_DA);
                stall_tot += lo;
            end
            push_cyc(3'b100, rb(), rb(), rb(), rb(),
                     {5'b00001, 1'b0, c & ~b, 1'b1, c & b, 1'b0});
        end
        run = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            cyc();
            is_mem = q[i].im; is_branch = q[i].ib; cond_pass = q[i].cp; mem_ack = q[i].ack;
            #1;
            chk($sformatf("rand_state_c%0d", i), 32'(state), 32'(q[i].st));
            chk($sformatf("rand_outputs_c%0d", i), 32'(ovec()), 32'(q[i].ev));
            if (i == q.size() - 1) run = 1'b0;
        end
        mem_ack = 1'b0;
        cyc(); #1;
        chk("rand_end_idle", 32'(state), 32'd6);
        chk("rand_instr_count", 32'(instr_count), 32'(n_instr));
        chk("rand_stall_count", 32'(stall_count), 32'(stall_tot));
        chk("sat_instr_count", 32'(s_ic), 32'(n_instr > 3 ? 3 : n_instr));
        chk("sat_stall_count", 32'(s_sc), 32'(stall_tot > 3 ? 3 : stall_tot));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
